// File: rtl/ctrl_74hc165.sv
// rtl/ctrl_74hc165.sv - scan controller for a daisy-chained 74HC165 input shift register
//
// Purpose:
//   This block repeatedly parallel-loads a chain of 74HC165 parallel-in/serial-out
//   registers. It then clocks WIDTH bits out of the last chip's Q7, MSB first.
//   Each completed frame is presented as a parallel word with a one-cycle valid strobe.
//
// Parameters:
//   WIDTH  bits in the chain (8 per chip), >= 2
//   DIV    system clocks per pin phase (PL low, CP low, CP high), >= 4
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   i_en     scan enable, only looked at while idle
//   i_q7     serial data from the last chip's Q7 (asynchronous)
//   o_pl_n   parallel load to all chips, active low
//   o_cp     shift clock to all chips
//   o_ce_n   clock enable to all chips, active low
//   o_data   last completed frame; first bit shifted out is o_data[WIDTH-1]
//   o_valid  one-cycle strobe coincident with o_data updating

module ctrl_74hc165 #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_q7,
  output logic             o_pl_n,
  output logic             o_cp,
  output logic             o_ce_n,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_phase;
  logic [BW-1:0]    r_bit;
  logic [1:0]       r_sync;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic             r_pl_n;
  logic             r_cp;
  logic             r_ce_n;
  logic             r_valid;

  logic             w_q7_s;
  logic             w_phase_last;
  logic             w_bit_last;
  logic             w_sample;
  logic [WIDTH-1:0] w_shift;
  logic             w_pl_n;
  logic             w_cp;
  logic             w_ce_n;
  logic             w_valid;

  assign w_q7_s       = r_sync[1];
  assign w_phase_last = (r_phase == PW'(DIV - 1));
  assign w_bit_last   = (r_bit == BW'(WIDTH - 1));
  // Q7 is sampled at the end of each CP-low phase. By then the data has been stable for
  // DIV cycles since the previous CP rise or the PL release.
  assign w_sample     = (r_state == ST_LOW) && w_phase_last;
  assign w_shift      = {r_shreg[WIDTH-2:0], w_q7_s};

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_en) w_next = ST_LOAD;
      ST_LOAD: if (w_phase_last) w_next = ST_LOW;
      ST_LOW: begin
        if (w_phase_last) begin
          // No CP rise follows the last sample, so the frame has WIDTH-1 rises.
          w_next = w_bit_last ? ST_DONE : ST_HIGH;
        end
      end
      ST_HIGH: if (w_phase_last) w_next = ST_LOW;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Pin and strobe decode from the state about to be entered. Registering the result
  // keeps the pins glitch-free and free of any combinational path from the inputs.
  always_comb begin
    w_pl_n  = 1'b1;
    w_cp    = 1'b0;
    w_ce_n  = 1'b1;
    w_valid = 1'b0;
    case (w_next)
      ST_LOAD: w_pl_n = 1'b0;
      ST_LOW:  w_ce_n = 1'b0;
      ST_HIGH: begin
        w_cp   = 1'b1;
        w_ce_n = 1'b0;
      end
      ST_DONE: begin
        w_ce_n  = 1'b0;
        w_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_sync  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_pl_n  <= 1'b1;
      r_cp    <= 1'b0;
      r_ce_n  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], i_q7};

      // The phase counter restarts on every state change and runs only in timed states.
      if (w_next != r_state) begin
        r_phase <= '0;
      end else if ((r_state == ST_LOAD) || (r_state == ST_LOW) || (r_state == ST_HIGH)) begin
        r_phase <= r_phase + PW'(1);
      end

      if (r_state == ST_LOAD) begin
        r_bit <= '0;
      end else if (w_sample && !w_bit_last) begin
        r_bit <= r_bit + BW'(1);
      end

      if (w_sample) begin
        r_shreg <= w_shift;
      end

      // The output word is captured together with the final sample. It is therefore
      // already updated during the DONE cycle in which o_valid is high.
      if (w_sample && w_bit_last) begin
        r_data <= w_shift;
      end

      r_pl_n  <= w_pl_n;
      r_cp    <= w_cp;
      r_ce_n  <= w_ce_n;
      r_valid <= w_valid;
    end
  end

  assign o_pl_n  = r_pl_n;
  assign o_cp    = r_cp;
  assign o_ce_n  = r_ce_n;
  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
